// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DATA_N   = 2;
  localparam int DEF_TAG_W    = 5;

  localparam int IF_ID_CTRL_W = 1;
  localparam int ID_EX_CTRL_W = 8;
  localparam int EX_M_CTRL_W  = 4;
  localparam int M_WB_CTRL_W  = 2;

  // The state encoding doubles as the entry count.
  function automatic logic [1:0] occ_of(input pipe_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One ctrl/data/tag holding register; clear kills the ctrl bits but keeps data and tag.
module pipe_entry #(
  parameter int CTRL_W    = 2,
  parameter int DATA_BITS = 64,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic [TAG_W-1:0]     tag_o
);

  logic [CTRL_W-1:0]    ctrl_q;
  logic [DATA_BITS-1:0] data_q;
  logic [TAG_W-1:0]     tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (clear_i) begin
      ctrl_q <= '0;
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
      tag_q  <= tag_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: valid/ready handshake, two-entry skid buffer, flush kills ctrl bits.
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   BUSY  | main entry valid, skid empty
//   FULL  | main and skid both valid, in_ready=0
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DATA_N = DEF_DATA_N,
  parameter int CTRL_W = M_WB_CTRL_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [DATA_N*DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_N*DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               occ
);

  localparam int DB = DATA_N * DATA_W;

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;
  logic        ld_main, main_from_skid, clr_main;
  logic        ld_skid, clr_skid;

  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
  logic [DB-1:0]     skid_data, main_data_d;
  logic [TAG_W-1:0]  skid_tag,  main_tag_d;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    main_from_skid = 1'b0;
    clr_main       = 1'b0;
    ld_skid        = 1'b0;
    clr_skid       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = BUSY;
          ld_main = 1'b1;
        end
        BUSY: begin
          if (accept && drain) begin
            ld_main = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (drain) begin
            state_d  = EMPTY;
            clr_main = 1'b1;
          end
        end
        FULL: if (drain) begin
          state_d        = BUSY;
          ld_main        = 1'b1;
          main_from_skid = 1'b1;
          clr_skid       = 1'b1;
        end
        default: begin
          state_d  = EMPTY;
          clr_main = 1'b1;
          clr_skid = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_tag_d  = main_from_skid ? skid_tag  : in_tag;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_BITS(DB), .TAG_W(TAG_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld_main),
    .clear_i (clr_main),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .tag_i   (main_tag_d),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data),
    .tag_o   (out_tag)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_BITS(DB), .TAG_W(TAG_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld_skid),
    .clear_i (clr_skid),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .tag_i   (in_tag),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data),
    .tag_o   (skid_tag)
  );

  assign in_ready = in_ready_q;
  assign occ      = occ_of(state_q);

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register for the inter-stage boundaries of the 5-stage core (IF/ID, ID/EX, EX/M, M/WB). It replaces fixed-width stall-enable registers with a valid/ready handshake and a two-entry skid buffer, giving full throughput with no combinational ready path from downstream to upstream. It adds a flush input that kills in-flight entries and forces control bits to zero, so a squashed bubble can never assert RegWrite, MemWrite or similar.

## Interface
- DATA_W, 32: width of each data word (read data, ALU result).
- DATA_N, 2: number of data words carried per entry.
- CTRL_W, 2: width of control bundle (e.g. {MemtoReg, RegWrite}); zeroed on invalid entries.
- TAG_W, 5: width of register-tag field (write-register number).
- clk  in  1  clock; all state updates on rising edge. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept; registered.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_N*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W].
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream consumes.
- out_ctrl  out  CTRL_W  control bundle; 0 whenever out_valid=0.
- out_data  out  DATA_N*DATA_W  data words.
- out_tag  out  TAG_W  register tag.
- occ  out  2  entries held: 0, 1 or 2.

## Operation
- Two entries: main (drives out_*) and skid. State: EMPTY (none), BUSY (main only), FULL (main+skid).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> BUSY, main<=in.
- BUSY: accept&drain -> BUSY, main<=in; accept&!drain -> FULL, skid<=in; !accept&drain -> EMPTY; else hold.
- FULL: drain -> BUSY, main<=skid; else hold. in_ready=0, so no accept.
- in_ready = (next state != FULL), registered.
- out_valid = (state != EMPTY); occ = 0/1/2 for EMPTY/BUSY/FULL.
- Whenever main becomes invalid (drain to EMPTY, flush), main ctrl is cleared to 0. Data and tag retain their last value.
- flush (rst clear): next state EMPTY, both ctrl fields cleared, in_ready<=1. A simultaneous accept is discarded. A simultaneous drain still completes downstream, since out_* were valid that cycle.
- Priority: rst > flush > handshake.
- Entry order is strictly FIFO. No entry is duplicated or lost without flush.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, out_tag=0, occ=0, in_ready=1 (from the first cycle after rst deasserts). Inputs are ignored while rst=1.
- Latency: an entry accepted at edge n appears on out_* after edge n (1 cycle) when the block is EMPTY or draining.
- Throughput: 1 entry/cycle while out_ready=1.
- out_ready may drop at any cycle. At most one extra entry is absorbed (into skid) before in_ready falls.
- All outputs come straight from registers, with no combinational input-to-output path.
- Reset mid-operation: both entries are discarded in the same edge, with no partial drain.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding typedef (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2);
  - the default width constants (DATA_W=32, TAG_W=5);
  - per-stage CTRL_W constants (M_WB_CTRL_W=2, EX_M_CTRL_W=4, ...).
- A sub-module pipe_entry (ctrl/data/tag register with load and ctrl-clear) is natural; it is instantiated twice, for main and skid.
- Target: about 150–250 lines of RTL.

## Test plan
- Reset then stream: rst 2 cycles, then in_valid=1 with tags 1..8 and out_ready=1 -> out_tag 1..8 on 8 consecutive cycles, occ=1 throughout, in_ready=1.
- Back-pressure: BUSY with tag 3, out_ready=0, in_valid with tag 4 -> occ=2, in_ready=0 next cycle. out_ready=1 -> tags 3 then 4, no loss or duplication.
- Flush while FULL with ctrl 2'b11 in both entries -> next cycle out_valid=0, out_ctrl=2'b00, occ=0, in_ready=1.
- Flush together with in_valid (tag 9) -> tag 9 never appears on out_tag.
- Mid-stream reset: FULL, rst=1 one cycle -> out_valid=0, out_data=0, out_tag=0, occ=0. The prior entries never emerge.
- Random valid/ready at 50% for 10k cycles with DATA_N=2 and DATA_W=32 -> scoreboard shows in-order, lossless delivery, and out_ctrl=0 whenever out_valid=0.
